onehot_to_bin_stage: RTL
========================

// Module: onehot_to_bin_stage
// PURPOSE
//   Downstream consumer of the binary-to-one-hot decoder output. Accepts an N-bit
//   one-hot vector over a valid/ready handshake and encodes it back to a binary index.
//   Flags any non-one-hot input and keeps a saturating count of those errors.
//   Results go out through a 2-entry skid buffer, so a stalled consumer never drops data.
// PARAMETERS
//   N          4   one-hot input width (N >= 2)
//   W          2   binary output width; must equal $clog2(N)
//   ERR_CNT_W  8   error counter width
// PORTS
//   clk        in   1          rising-edge clock; only clock
//   rst_n      in   1          synchronous active-low reset
//   in_valid   in   1          upstream vector valid
//   in_ready   out  1          stage can accept this cycle
//   in_onehot  in   N          one-hot vector from the decoder
//   out_valid  out  1          head entry valid
//   out_ready  in   1          downstream accepts head entry
//   out_bin    out  W          encoded index of head entry
//   out_err    out  1          head entry came from a non-one-hot input
//   err_count  out  ERR_CNT_W  saturating count of accepted error entries
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge clk): the stage is flushed.
//     - state=EMPTY, out_valid=0, out_bin=0, out_err=0, err_count=0.
//     - in_ready is registered; it resets to 0 and rises on the first edge after rst_n=1.
//   - Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are sampled at posedge.
//   - Encode, with popcount(in_onehot)==1: bin = index of the set bit, err = 0.
//   - Encode, with popcount 0 or >1: bin = 0, err = 1. The entry is still stored and
//     forwarded, never dropped.
//   - Latency: a vector pushed in cycle t shows on out_* in cycle t+1 when the buffer was
//     EMPTY. Otherwise it shows after the older entries pop (FIFO order).
//   - out_bin and out_err come straight from flops (head entry). They stay stable while
//     out_valid=1 and out_ready=0.
//   - State machine, based on occupancy:
//     - EMPTY: push -> ONE.
//     - ONE:
//       - push & !pop -> FULL
//       - pop & !push -> EMPTY
//       - push & pop -> ONE, with the new entry becoming the head next cycle
//       - neither -> ONE
//     - FULL: pop -> ONE, and the second entry becomes the head. A push cannot happen
//       because in_ready=0.
//   - in_ready next = (next state != FULL). Registered, so no combinational path from
//     out_ready to in_ready.
//   - out_valid = (state != EMPTY).
//   - err_count increments by 1 on each push with err=1. It holds at 2^ERR_CNT_W-1 and
//     does not wrap. Only reset clears it.
//   - in_valid while in_ready=0 is ignored; upstream must hold its data.
//   - Reset mid-transfer discards both buffered entries. No partial output.
// CONFIGURATION
//   PRIORITY_FALLBACK_EN
//     - Defined: a multi-hot input encodes to the lowest set bit index, and err stays 1.
//       An all-zero input still gives bin=0, err=1.
//     - Not defined: every non-one-hot input gives bin=0, err=1 (base behaviour above).
//     - The handshake, latency and err_count are the same in both builds.
// TESTING (N=4, W=2, ERR_CNT_W=8)
//   1. Reset with in_valid=1. After release: in_ready=0 in the first cycle and 1 in the
//      next; out_valid=0; err_count=0.
//   2. Push 0001,0010,0100,1000 back-to-back with out_ready=1 -> out_bin 0,1,2,3 on
//      consecutive cycles, each one cycle after push, out_err=0.
//   3. Hold out_ready=0 and push 0100 then 1000 -> FULL, in_ready=0, out_bin=2 stays held.
//      Then out_ready=1 -> 2 then 3, and in_ready goes back to 1.
//   4. Push 0000, then 0110 -> out_err=1 both times, err_count=2. out_bin=0,0 without the
//      macro, or 0,1 with PRIORITY_FALLBACK_EN.
//   5. Push 300 consecutive 1111 vectors -> err_count saturates at 255 and stays there.
//   6. With two entries buffered, pull rst_n low for one cycle -> out_valid=0 and
//      err_count=0 next cycle, and no stale entry ever appears on out_bin.

Source files
------------

// File: rtl/onehot_to_bin_stage.sv
// One-hot to binary encoder stage with error flagging, saturating error count and 2-entry skid output.
// Latency: 1 cycle from push to out_* when empty; otherwise FIFO order behind buffered entries.
// Backpressure: in_ready is registered and drops only when both entries are held; optional macro PRIORITY_FALLBACK_EN.
module onehot_to_bin_stage #(
  parameter int N         = 4,
  parameter int W         = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_bin,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic [W-1:0]         head_bin_q, head_bin_d;
  logic                 head_err_q, head_err_d;
  logic [W-1:0]         tail_bin_q, tail_bin_d;
  logic                 tail_err_q, tail_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [W:0]   ones;
  logic [W-1:0] low_idx;
  logic [W-1:0] enc_bin;
  logic         enc_err;
  logic         push;
  logic         pop;

  assign push = in_valid & in_ready_q;
  assign pop  = (state_q != EMPTY) & out_ready;

  // Encode: count set bits and find the lowest set index; any count other than one is an error.
  always_comb begin
    ones    = '0;
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_onehot[i]) begin
        ones    = ones + (W + 1)'(1);
        low_idx = W'(i);
      end
    end
    enc_err = (ones != (W + 1)'(1));
`ifdef PRIORITY_FALLBACK_EN
    // Multi-hot resolves to the lowest set bit; all-zero still encodes as 0.
    enc_bin = (ones == '0) ? '0 : low_idx;
`else
    enc_bin = enc_err ? '0 : low_idx;
`endif
  end

  // Occupancy FSM and skid-buffer data movement; in_ready is precomputed from the next state.
  always_comb begin
    state_d    = state_q;
    head_bin_d = head_bin_q;
    head_err_d = head_err_q;
    tail_bin_d = tail_bin_q;
    tail_err_d = tail_err_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_bin_d = enc_bin;
          head_err_d = enc_err;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_bin_d = enc_bin;
          head_err_d = enc_err;
        end else if (push) begin
          tail_bin_d = enc_bin;
          tail_err_d = enc_err;
          state_d    = FULL;
        end else if (pop) begin
          state_d    = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_bin_d = tail_bin_q;
          head_err_d = tail_err_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  // Saturating count of accepted error entries.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // State and data registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      head_bin_q <= '0;
      head_err_q <= 1'b0;
      tail_bin_q <= '0;
      tail_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_bin_q <= head_bin_d;
      head_err_q <= head_err_d;
      tail_bin_q <= tail_bin_d;
      tail_err_q <= tail_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_bin   = head_bin_q;
  assign out_err   = head_err_q;
  assign err_count = err_cnt_q;

endmodule
